// File: rtl/multicycle_ctrl.sv
// Main controller for the multi-cycle MIPS datapath: sequences the shared memory
// port, ALU and immediate extender through fetch/decode/execute/memory/writeback.
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ext_sel_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd2;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op_q;

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal_op = 1'b1;
            default:                                                   legal_op = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= op_i;
            end
        end
    end

    // Decode dispatches on the live opcode; every later decision uses the latched copy.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_R:           state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset masks every output, so strobes drop as soon as rst_i goes low.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ext_sel_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = ALU_ADD;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        pc_src_o     = 2'd0;
        state_o      = 4'd0;
        illegal_o    = 1'b0;
        if (rst_i) begin
            state_o = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'd1;
                    pc_write_o  = mem_ready_i;
                    ir_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'd3;
                    ext_sel_o   = 1'b1;
                    illegal_o   = !legal_op(op_i);
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    ext_sel_o   = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    iord_o    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    ext_sel_o   = (op_q != OP_ORI);
                    alu_op_o    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
                end
                S_ALU_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (op_q == OP_R);
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_SUB;
                    pc_src_o    = 2'd1;
                    pc_write_o  = (op_q == OP_BNE) ? !zero_i : zero_i;
                end
                S_JUMP: begin
                    pc_src_o   = 2'd2;
                    pc_write_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle expected output words are
// queued as stimulus is driven and compared against the packed DUT outputs.
module tb_multicycle_ctrl;

    typedef logic [20:0] ow_t;

    // Output word layout: pcw irw mreq mwe iord ext srca srcb[2] aop[2] rw rdst m2r pcs[2] ill state[4]
    localparam ow_t PCW  = ow_t'(1) << 20;
    localparam ow_t IRW  = ow_t'(1) << 19;
    localparam ow_t MREQ = ow_t'(1) << 18;
    localparam ow_t MWE  = ow_t'(1) << 17;
    localparam ow_t IORD = ow_t'(1) << 16;
    localparam ow_t EXT  = ow_t'(1) << 15;
    localparam ow_t SRCA = ow_t'(1) << 14;
    localparam ow_t SB1  = ow_t'(1) << 12;
    localparam ow_t SB2  = ow_t'(2) << 12;
    localparam ow_t SB3  = ow_t'(3) << 12;
    localparam ow_t AOP1 = ow_t'(1) << 10;
    localparam ow_t AOP2 = ow_t'(2) << 10;
    localparam ow_t AOP3 = ow_t'(3) << 10;
    localparam ow_t RW   = ow_t'(1) << 9;
    localparam ow_t RDST = ow_t'(1) << 8;
    localparam ow_t M2R  = ow_t'(1) << 7;
    localparam ow_t PCS1 = ow_t'(1) << 5;
    localparam ow_t PCS2 = ow_t'(2) << 5;
    localparam ow_t ILL  = ow_t'(1) << 4;

    localparam ow_t ZERO    = '0;
    localparam ow_t F_RDY   = ow_t'(0)  | MREQ | SB1 | PCW | IRW;
    localparam ow_t F_WAIT  = ow_t'(0)  | MREQ | SB1;
    localparam ow_t DEC     = ow_t'(1)  | SB3 | EXT;
    localparam ow_t DEC_ILL = ow_t'(1)  | SB3 | EXT | ILL;
    localparam ow_t MADDR   = ow_t'(2)  | SRCA | SB2 | EXT;
    localparam ow_t MRD     = ow_t'(3)  | MREQ | IORD;
    localparam ow_t MWB     = ow_t'(4)  | RW | M2R;
    localparam ow_t MWR     = ow_t'(5)  | MREQ | MWE | IORD;
    localparam ow_t EXR     = ow_t'(6)  | SRCA | AOP2;
    localparam ow_t EXI_ADD = ow_t'(7)  | SRCA | SB2 | EXT;
    localparam ow_t EXI_OR  = ow_t'(7)  | SRCA | SB2 | AOP3;
    localparam ow_t AWB_R   = ow_t'(8)  | RW | RDST;
    localparam ow_t AWB_I   = ow_t'(8)  | RW;
    localparam ow_t BR_T    = ow_t'(9)  | SRCA | AOP1 | PCS1 | PCW;
    localparam ow_t BR_N    = ow_t'(9)  | SRCA | AOP1 | PCS1;
    localparam ow_t JMP     = ow_t'(10) | PCS2 | PCW;

    typedef struct packed {
        logic [5:0]       op;
        logic [5:0]       late;
        logic             zero;
        logic [3:0]       len;
        logic [7:0]       rdy;
        logic [7:0][20:0] seq;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [5:0] op_i = 6'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b1;
    logic       pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, ext_sel_o;
    logic       alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o;
    logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
    logic [3:0] state_o;

    vec_t vecs[20];
    int   nvec = 0;
    ow_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .iord_o(iord_o), .ext_sel_o(ext_sel_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .pc_src_o(pc_src_o), .state_o(state_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    ow_t got;
    assign got = {pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, ext_sel_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
                  mem_to_reg_o, pc_src_o, illegal_o, state_o};

    task automatic add(input logic [5:0] op, input logic [5:0] late, input logic z,
                       input int len, input logic [7:0] rdy,
                       input ow_t s0, input ow_t s1, input ow_t s2, input ow_t s3,
                       input ow_t s4, input ow_t s5, input ow_t s6);
        vecs[nvec].op     = op;
        vecs[nvec].late   = late;
        vecs[nvec].zero   = z;
        vecs[nvec].len    = 4'(len);
        vecs[nvec].rdy    = rdy;
        vecs[nvec].seq[0] = s0;
        vecs[nvec].seq[1] = s1;
        vecs[nvec].seq[2] = s2;
        vecs[nvec].seq[3] = s3;
        vecs[nvec].seq[4] = s4;
        vecs[nvec].seq[5] = s5;
        vecs[nvec].seq[6] = s6;
        vecs[nvec].seq[7] = ZERO;
        nvec++;
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [5:0] op, input logic z,
                       input ow_t e, input string name, input int idx);
        ow_t exp_w;
        @(posedge clk);
        #1;
        rst_i       = r;
        mem_ready_i = rd;
        op_i        = op;
        zero_i      = z;
        sb.push_back(e);
        @(negedge clk);
        exp_w = sb.pop_front();
        checks++;
        if (got !== exp_w) begin
            errors++;
            $display("FAIL %s[%0d]: outputs=%h required=%h (state_o=%0d)", name, idx, got, exp_w, state_o);
        end
    endtask

    initial begin
        add(6'd0,  6'd0,  0, 4, 8'hFF, F_RDY, DEC, EXR, AWB_R, ZERO, ZERO, ZERO);
        add(6'd8,  6'd8,  0, 4, 8'hFF, F_RDY, DEC, EXI_ADD, AWB_I, ZERO, ZERO, ZERO);
        add(6'd13, 6'd13, 0, 4, 8'hFF, F_RDY, DEC, EXI_OR, AWB_I, ZERO, ZERO, ZERO);
        add(6'd35, 6'd35, 0, 5, 8'hFF, F_RDY, DEC, MADDR, MRD, MWB, ZERO, ZERO);
        add(6'd43, 6'd43, 0, 4, 8'hFF, F_RDY, DEC, MADDR, MWR, ZERO, ZERO, ZERO);
        add(6'd4,  6'd4,  1, 3, 8'hFF, F_RDY, DEC, BR_T, ZERO, ZERO, ZERO, ZERO);
        add(6'd4,  6'd4,  0, 3, 8'hFF, F_RDY, DEC, BR_N, ZERO, ZERO, ZERO, ZERO);
        add(6'd5,  6'd5,  1, 3, 8'hFF, F_RDY, DEC, BR_N, ZERO, ZERO, ZERO, ZERO);
        add(6'd5,  6'd5,  0, 3, 8'hFF, F_RDY, DEC, BR_T, ZERO, ZERO, ZERO, ZERO);
        add(6'd2,  6'd2,  0, 3, 8'hFF, F_RDY, DEC, JMP, ZERO, ZERO, ZERO, ZERO);
        add(6'h3F, 6'h3F, 0, 2, 8'hFF, F_RDY, DEC_ILL, ZERO, ZERO, ZERO, ZERO, ZERO);
        add(6'd1,  6'd1,  1, 2, 8'hFF, F_RDY, DEC_ILL, ZERO, ZERO, ZERO, ZERO, ZERO);
        // lw with two MEM_RD wait cycles, then a fetch wait and a write wait.
        add(6'd35, 6'd35, 0, 7, 8'hE7, F_RDY, DEC, MADDR, MRD, MRD, MRD, MWB);
        add(6'd0,  6'd0,  0, 5, 8'hFE, F_WAIT, F_RDY, DEC, EXR, AWB_R, ZERO, ZERO);
        add(6'd43, 6'd43, 0, 5, 8'hF7, F_RDY, DEC, MADDR, MWR, MWR, ZERO, ZERO);
        // mem_ready_i low outside memory states changes nothing; opcode changes after DECODE are ignored.
        add(6'd0,  6'd8,  0, 4, 8'h05, F_RDY, DEC, EXR, AWB_R, ZERO, ZERO, ZERO);
        add(6'd8,  6'd13, 1, 4, 8'hFF, F_RDY, DEC, EXI_ADD, AWB_I, ZERO, ZERO, ZERO);
        add(6'd13, 6'd8,  0, 4, 8'hFF, F_RDY, DEC, EXI_OR, AWB_I, ZERO, ZERO, ZERO);
        add(6'd4,  6'd5,  1, 3, 8'hFF, F_RDY, DEC, BR_T, ZERO, ZERO, ZERO, ZERO);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 6'd0, 1'b0, ZERO, "reset", i);

        for (int v = 0; v < nvec; v++) begin
            for (int c = 0; c < int'(vecs[v].len); c++) begin
                cyc(1'b1, vecs[v].rdy[c], (c >= 2) ? vecs[v].late : vecs[v].op,
                    vecs[v].zero, ow_t'(vecs[v].seq[c]), "vec", v * 10 + c);
            end
        end

        // Reset while sw waits in MEM_WR, then a clean R-type afterwards.
        cyc(1'b1, 1'b1, 6'd43, 1'b0, F_RDY, "sw_rst", 0);
        cyc(1'b1, 1'b1, 6'd43, 1'b0, DEC,   "sw_rst", 1);
        cyc(1'b1, 1'b1, 6'd43, 1'b0, MADDR, "sw_rst", 2);
        cyc(1'b1, 1'b0, 6'd43, 1'b0, MWR,   "sw_rst", 3);
        cyc(1'b0, 1'b0, 6'd43, 1'b0, ZERO,  "sw_rst", 4);
        cyc(1'b1, 1'b1, 6'd0,  1'b0, F_RDY, "sw_rst", 5);
        cyc(1'b1, 1'b1, 6'd0,  1'b0, DEC,   "sw_rst", 6);
        cyc(1'b1, 1'b1, 6'd0,  1'b0, EXR,   "sw_rst", 7);
        cyc(1'b1, 1'b1, 6'd0,  1'b0, AWB_R, "sw_rst", 8);

        // Reset during a fetch wait also holds every output low.
        cyc(1'b1, 1'b0, 6'd0, 1'b0, F_WAIT, "f_rst", 0);
        cyc(1'b0, 1'b1, 6'd0, 1'b0, ZERO,   "f_rst", 1);
        cyc(1'b1, 1'b1, 6'd2, 1'b0, F_RDY,  "f_rst", 2);
        cyc(1'b1, 1'b1, 6'd2, 1'b0, DEC,    "f_rst", 3);
        cyc(1'b1, 1'b1, 6'd2, 1'b0, JMP,    "f_rst", 4);
        cyc(1'b1, 1'b1, 6'd2, 1'b0, F_RDY,  "f_rst", 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
